sprite_anim_ctrl: RTL

- Animation sequencer for the 16x16 character sprite renderer.
- Drives the renderer's sprite_sel_x/sprite_sel_y sheet offsets: sheet row = facing direction, sheet column = walk phase.
- Advances animation only at a once-per-frame strobe taken in vertical blanking, so the selected tile never changes mid-frame.
- Implements Pokemon-style turn-in-place and step-quantised walking.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/frame_strobe_gen.sv | 28 ++
 rtl/sprite_anim_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite animation blocks.
package sprite_pkg;

    localparam int TILE_PX = 16;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        WALK = 2'd2
    } anim_state_t;

    // Walk cycle: stand, left foot, stand, right foot.
    function automatic logic [1:0] phase_to_col(input logic [1:0] phase);
        logic [1:0] col;
        case (phase)
            2'd1:    col = 2'd1;
            2'd3:    col = 2'd2;
            default: col = 2'd0;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/frame_strobe_gen.sv
// Registered once-per-frame strobe, raised for one cycle after the
// first pixel of the chosen blanking line.
module frame_strobe_gen #(
    parameter int V_STROBE = 768
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    output logic        strobe_o
);

    logic strobe_q;
    logic strobe_d;

    assign strobe_d = (hcount_i == 11'd0) && (vcount_i == 10'(V_STROBE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Per-frame animation sequencer: turn-in-place and step-quantised walking,
// producing sheet offsets for the 16x16 sprite renderer.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int TILE            = 16,
    parameter int FRAMES_PER_STEP = 8,
    parameter int TURN_FRAMES     = 4,
    parameter int V_STROBE        = 768
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        enable_in,
    input  logic        move_in,
    input  logic [1:0]  dir_in,
    output logic [5:0]  sprite_sel_x,
    output logic [5:0]  sprite_sel_y,
    output logic        frame_tick_out,
    output logic        walking_out,
    output logic        step_done_out
);

    generate
        if (FRAMES_PER_STEP < 2 || FRAMES_PER_STEP > 15) begin : g_bad_fps
            $fatal(1, "sprite_anim_ctrl: FRAMES_PER_STEP out of range 2..15");
        end
        if (TURN_FRAMES < 1 || TURN_FRAMES > 15) begin : g_bad_turn
            $fatal(1, "sprite_anim_ctrl: TURN_FRAMES out of range 1..15");
        end
    endgenerate

    localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_FRAMES - 1);

    logic        strobe;
    logic        adv;

    anim_state_t state_q, state_d;
    dir_t        facing_q, facing_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  div_q, div_d;
    logic        step_done_d;

    logic [5:0]  sel_x_q, sel_x_d;
    logic [5:0]  sel_y_q, sel_y_d;
    logic        walking_q, walking_d;
    logic        step_done_q;

    frame_strobe_gen #(
        .V_STROBE (V_STROBE)
    ) u_strobe (
        .clk_i    (pixel_clk_in),
        .rst_i    (rst_in),
        .hcount_i (hcount_in),
        .vcount_i (vcount_in),
        .strobe_o (strobe)
    );

    // A strobe that arrives while disabled is simply lost.
    assign adv = strobe && enable_in;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            facing_q    <= DIR_DOWN;
            phase_q     <= 2'd0;
            div_q       <= 4'd0;
            sel_x_q     <= 6'd0;
            sel_y_q     <= 6'd0;
            walking_q   <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            facing_q    <= facing_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            sel_x_q     <= sel_x_d;
            sel_y_q     <= sel_y_d;
            walking_q   <= walking_d;
            step_done_q <= step_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        facing_d    = facing_q;
        phase_d     = phase_q;
        div_d       = div_q;
        step_done_d = 1'b0;
        if (adv) begin
            case (state_q)
                IDLE: begin
                    phase_d = 2'd0;
                    if (!move_in) begin
                        facing_d = dir_t'(dir_in);
                    end else if (dir_t'(dir_in) != facing_q) begin
                        facing_d = dir_t'(dir_in);
                        div_d    = 4'd0;
                        state_d  = TURN;
                    end else begin
                        phase_d = 2'd1;
                        div_d   = 4'd0;
                        state_d = WALK;
                    end
                end
                TURN: begin
                    if (div_q == TURN_LAST) begin
                        div_d = 4'd0;
                        if (move_in) begin
                            state_d  = WALK;
                            phase_d  = 2'd1;
                            facing_d = dir_t'(dir_in);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
                WALK: begin
                    // Inputs only matter at the step boundary.
                    if (div_q == STEP_LAST) begin
                        div_d = 4'd0;
                        if (move_in) begin
                            phase_d  = phase_q + 2'd1;
                            facing_d = dir_t'(dir_in);
                        end else begin
                            phase_d     = 2'd0;
                            state_d     = IDLE;
                            step_done_d = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = 2'd0;
                    div_d   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        sel_x_d   = 6'(int'(phase_to_col(phase_d)) * TILE);
        sel_y_d   = 6'(int'(facing_d) * TILE);
        walking_d = (state_d == WALK);
    end

    assign sprite_sel_x   = sel_x_q;
    assign sprite_sel_y   = sel_y_q;
    assign frame_tick_out = strobe;
    assign walking_out    = walking_q;
    assign step_done_out  = step_done_q;

endmodule
